fixed_point_divider_q: RTL and testbench

Parametrised sequential Qm.n fixed-point divider computing Q = (A << FRAC) / B.
- Replaces the fixed 32-bit / fixed-scale divider. Adds:
  - selectable signed/unsigned mode per operation
  - remainder output
  - divide-by-zero and overflow flags
  - a single-cycle done strobe with back-to-back issue
- Restoring radix-2 algorithm, one quotient bit per clock. Sits beside the FPU datapath and is driven by the execution-unit sequencer.

---
 rtl/fixed_point_divider_q.sv | 219 +++++++++++++++++++++
 tb/tb_fixed_point_divider_q.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider_q.sv
// Sequential restoring radix-2 Qm.n divider: Q = (A << FRAC) / B, one quotient bit per clock.
// Optional macro FXDIV_SATURATE_EN clamps the quotient on overflow instead of wrapping.
module fixed_point_divider_q #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivByZero,
  output logic             oOverflow
);

  localparam int unsigned NW = WIDTH + FRAC;
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned SW = WIDTH + 2;
  localparam int unsigned CW = $clog2(NW + 1);

  localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t state, state_nxt;

  logic [NW-1:0]    num_q;
  logic [NW-1:0]    quo_q;
  logic [RW-1:0]    rem_q;
  logic [WIDTH-1:0] bmag_q;
  logic [WIDTH-1:0] dvd_q;
  logic [CW-1:0]    cnt_q;
  logic             sgn_q;
  logic             aneg_q;
  logic             bneg_q;
  logic             dz_q;

  logic             idle_c;
  logic             accept_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic             b_zero_c;

  logic [SW-1:0]    rem_sh_c;
  logic [SW-1:0]    div_ext_c;
  logic             qbit_c;

  logic             fin_c;
  logic             neg_q_c;
  logic [WIDTH-1:0] q_wrap_c;
  logic [WIDTH-1:0] q_fix_c;
  logic [WIDTH-1:0] r_fix_c;
  logic [WIDTH-1:0] dz_quo_c;
  logic             ov_c;

  logic             busy_d;
  logic             done_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_d;
  logic             dz_d;
  logic             ov_d;

  // Operand capture: magnitudes only for signed operations with MSB set
  assign idle_c   = (state == IDLE) || (state == DONE);
  assign accept_c = idle_c && iStart;
  assign a_neg_c  = iSigned & iDividend[WIDTH-1];
  assign b_neg_c  = iSigned & iDivisor[WIDTH-1];
  assign a_mag_c  = a_neg_c ? -iDividend : iDividend;
  assign b_mag_c  = b_neg_c ? -iDivisor : iDivisor;
  assign b_zero_c = (iDivisor == '0);

  // One restoring step: shift in next numerator bit, subtract divisor if it fits
  assign rem_sh_c  = {rem_q, num_q[NW-1]};
  assign div_ext_c = {2'b00, bmag_q};
  assign qbit_c    = (rem_sh_c >= div_ext_c);

  // Sign fixup and overflow detection on the full-width quotient magnitude
  assign fin_c    = (state == FIXUP) && (cnt_q == '0);
  assign neg_q_c  = sgn_q & (aneg_q ^ bneg_q);
  assign q_wrap_c = neg_q_c ? -quo_q[WIDTH-1:0] : quo_q[WIDTH-1:0];
  assign r_fix_c  = (sgn_q & aneg_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign dz_quo_c = !sgn_q ? UMAX : (aneg_q ? SMIN : SMAX);

  always_comb begin
    ov_c = 1'b0;
    if (!sgn_q)
      ov_c = (quo_q > NW'(UMAX));
    else if (neg_q_c)
      ov_c = (quo_q > NW'(SMIN));
    else
      ov_c = (quo_q > NW'(SMAX));
  end

`ifdef FXDIV_SATURATE_EN
  logic [WIDTH-1:0] q_sat_c;
  assign q_sat_c = !sgn_q ? UMAX : (neg_q_c ? SMIN : SMAX);
  assign q_fix_c = ov_c ? q_sat_c : q_wrap_c;
`else
  assign q_fix_c = q_wrap_c;
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; divide-by-zero dwells two cycles in FIXUP via the counter
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (iStart) state_nxt = b_zero_c ? FIXUP : CALC;
        else        state_nxt = IDLE;
      end
      CALC:    if (cnt_q == CW'(1)) state_nxt = FIXUP;
      FIXUP:   if (cnt_q == '0)     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output next-values; busy spans the cycles after acceptance up to the done strobe
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    quo_d  = oQuotient;
    rem_d  = oRemainder;
    dz_d   = oDivByZero;
    ov_d   = oOverflow;
    if (((state == CALC) || (state == FIXUP)) && (state_nxt != DONE))
      busy_d = 1'b1;
    if (fin_c) begin
      done_d = 1'b1;
      if (dz_q) begin
        quo_d = dz_quo_c;
        rem_d = dvd_q;
        dz_d  = 1'b1;
        ov_d  = 1'b0;
      end else begin
        quo_d = q_fix_c;
        rem_d = r_fix_c;
        dz_d  = 1'b0;
        ov_d  = ov_c;
      end
    end
  end

  // Output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oQuotient  <= '0;
      oRemainder <= '0;
      oDivByZero <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      oBusy      <= busy_d;
      oDone      <= done_d;
      oQuotient  <= quo_d;
      oRemainder <= rem_d;
      oDivByZero <= dz_d;
      oOverflow  <= ov_d;
    end
  end

  // Datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      num_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      bmag_q <= '0;
      dvd_q  <= '0;
      cnt_q  <= '0;
      sgn_q  <= 1'b0;
      aneg_q <= 1'b0;
      bneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            num_q  <= NW'(a_mag_c) << FRAC;
            quo_q  <= '0;
            rem_q  <= '0;
            bmag_q <= b_mag_c;
            dvd_q  <= iDividend;
            cnt_q  <= b_zero_c ? CW'(1) : CW'(NW);
            sgn_q  <= iSigned;
            aneg_q <= a_neg_c;
            bneg_q <= b_neg_c;
            dz_q   <= b_zero_c;
          end
        end
        CALC: begin
          num_q <= num_q << 1;
          quo_q <= {quo_q[NW-2:0], qbit_c};
          rem_q <= RW'(qbit_c ? (rem_sh_c - div_ext_c) : rem_sh_c);
          cnt_q <= cnt_q - CW'(1);
        end
        FIXUP: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider_q.sv
// Scoreboard bench for fixed_point_divider_q (WIDTH=32, FRAC=16) with an arithmetic reference model.
module tb_fixed_point_divider_q;

  localparam int unsigned W = 32;
  localparam int unsigned F = 16;
  localparam int LAT  = 49;
  localparam int LATZ = 2;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iStart;
  logic          iSigned;
  logic [W-1:0]  iDividend;
  logic [W-1:0]  iDivisor;
  logic          oBusy;
  logic          oDone;
  logic [W-1:0]  oQuotient;
  logic [W-1:0]  oRemainder;
  logic          oDivByZero;
  logic          oOverflow;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          done_cyc;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   busy_cnt = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;

  fixed_point_divider_q #(.WIDTH(W), .FRAC(F)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iStart     (iStart),
    .iSigned    (iSigned),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oDivByZero (oDivByZero),
    .oOverflow  (oOverflow)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dz, input logic ov);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.done_cyc = 0; e.busy = 0;
    return e;
  endfunction

  // Reference: plain 64-bit arithmetic on magnitudes, then sign/overflow rules
  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic        an, bn, neg;
    logic [31:0] am, bm, rlo, qsat;
    logic [63:0] n, qm, rm, qf;
    logic        ov;
    an = s & a[31];
    bn = s & b[31];
    am = an ? -a : a;
    bm = bn ? -b : b;
    if (b == 32'd0)
      return mk(!s ? 32'hFFFF_FFFF : (an ? 32'h8000_0000 : 32'h7FFF_FFFF), a, 1'b1, 1'b0);
    n   = {32'd0, am} << 16;
    qm  = n / {32'd0, bm};
    rm  = n % {32'd0, bm};
    neg = s & (an ^ bn);
    if (!s)     ov = (qm > 64'h0000_0000_FFFF_FFFF);
    else if (neg) ov = (qm > 64'h0000_0000_8000_0000);
    else        ov = (qm > 64'h0000_0000_7FFF_FFFF);
    qf  = neg ? -qm : qm;
    qsat = qf[31:0];
`ifdef FXDIV_SATURATE_EN
    if (ov) qsat = !s ? 32'hFFFF_FFFF : (neg ? 32'h8000_0000 : 32'h7FFF_FFFF);
`endif
    rlo = rm[31:0];
    return mk(qsat, (s & an) ? -rlo : rlo, 1'b0, ov);
  endfunction

  // Drive one request at this negedge; it is sampled on the next rising edge
  task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    exp_t x;
    x = e;
    x.done_cyc = cyc + 1 + ((b == 32'd0) ? LATZ : LAT);
    x.busy     = (b == 32'd0) ? 1 : LAT - 1;
    iStart = 1'b1; iSigned = s; iDividend = a; iDivisor = b;
    sb.push_back(x);
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    @(negedge Clock);
    while (sb.size() != 0 && t < 300) begin
      @(negedge Clock);
      t++;
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    wait_empty();
    drive(s, a, b, e);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
    chk({tag, "_done"}, {31'd0, oDone}, 32'd0);
    chk({tag, "_quo"},  oQuotient, 32'd0);
    chk({tag, "_rem"},  oRemainder, 32'd0);
    chk({tag, "_dz"},   {31'd0, oDivByZero}, 32'd0);
    chk({tag, "_ov"},   {31'd0, oOverflow}, 32'd0);
  endtask

  // Monitor: pop and compare whenever the DUT strobes oDone
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        busy_cnt = 0;
      end else if (oDone) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'd0, oDone}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient",   oQuotient, e.q);
          chk("remainder",  oRemainder, e.r);
          chk("divbyzero",  {31'd0, oDivByZero}, {31'd0, e.dz});
          chk("overflow",   {31'd0, oOverflow}, {31'd0, e.ov});
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_cycles", busy_cnt, e.busy);
          chk("busy_at_done", {31'd0, oBusy}, 32'd0);
        end
        busy_cnt = 0;
      end else begin
        if (oBusy) busy_cnt++;
        if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
          chk("timeout_done", {31'd0, oDone}, 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic        s;
    logic [31:0] a, b;
    int          t;
    Reset = 1'b1; iStart = 1'b0; iSigned = 1'b0; iDividend = '0; iDivisor = '0;
    repeat (3) @(negedge Clock);
    check_zero_outputs("reset");
    Reset = 1'b0;

    // Directed cases from the plan
    issue(1'b0, 32'h0001_8000, 32'h0000_8000, mk(32'h0003_0000, 32'h0, 1'b0, 1'b0));
    issue(1'b1, 32'hFFFD_0000, 32'h0002_0000, mk(32'hFFFE_8000, 32'h0, 1'b0, 1'b0));
    issue(1'b0, 32'h0001_0000, 32'h0003_0000, mk(32'h0000_5555, 32'h0001_0000, 1'b0, 1'b0));
    issue(1'b1, 32'hFFFF_0000, 32'h0,         mk(32'h8000_0000, 32'hFFFF_0000, 1'b1, 1'b0));
    issue(1'b0, 32'h0000_1234, 32'h0,         mk(32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0));
`ifdef FXDIV_SATURATE_EN
    issue(1'b0, 32'h7FFF_0000, 32'h1, mk(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1));
    issue(1'b1, 32'h7FFF_0000, 32'h1, mk(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1));
`else
    issue(1'b0, 32'h7FFF_0000, 32'h1, mk(32'h0000_0000, 32'h0, 1'b0, 1'b1));
    issue(1'b1, 32'h7FFF_0000, 32'h1, mk(32'h0000_0000, 32'h0, 1'b0, 1'b1));
`endif

    // Start pulse during CALC must be ignored
    issue(1'b0, 32'h0001_8000, 32'h0000_8000, mk(32'h0003_0000, 32'h0, 1'b0, 1'b0));
    repeat (10) @(negedge Clock);
    iStart = 1'b1; iSigned = 1'b1; iDividend = 32'h0000_0001; iDivisor = 32'h0000_0001;
    @(negedge Clock);
    iStart = 1'b0;

    // Back-to-back: second request accepted in the DONE cycle
    issue(1'b0, 32'h0001_0000, 32'h0003_0000, mk(32'h0000_5555, 32'h0001_0000, 1'b0, 1'b0));
    t = 0;
    while (!oDone && t < 100) begin
      @(negedge Clock);
      t++;
    end
    chk("b2b_first_done_seen", {31'd0, oDone}, 32'd1);
    drive(1'b1, 32'hFFFD_0000, 32'h0002_0000, mk(32'hFFFE_8000, 32'h0, 1'b0, 1'b0));

    // Reset in the middle of CALC discards the operation
    issue(1'b0, 32'h0012_3456, 32'h0000_0789, model(1'b0, 32'h0012_3456, 32'h0000_0789));
    repeat (20) @(negedge Clock);
    Reset = 1'b1;
    sb.delete();
    @(negedge Clock);
    check_zero_outputs("midreset");
    @(negedge Clock);
    Reset = 1'b0;
    issue(1'b1, 32'hFFFD_0000, 32'h0002_0000, mk(32'hFFFE_8000, 32'h0, 1'b0, 1'b0));

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = s ? -32'($urandom_range(1, 15)) : 32'($urandom_range(16, 4096));
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      issue(s, a, b, model(s, a, b));
    end

    wait_empty();
    repeat (5) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
